// File: rtl/id_pkg.sv
// Shared constants for the ID-stage register scoreboard: default pipeline depth,
// forwarding-select encoding and result-latency codes.
package id_pkg;

  localparam int STAGES_DEF = 3;

  // fwd_sel encoding: 0 reads the register file, k forwards from stage k.
  localparam int SEL_RF    = 0;
  localparam int SEL_EXMEM = 1;
  localparam int SEL_MEMWB = 2;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks whether a register has an in-flight writer, how far
// down the pipe that writer is (age) and from which age its result can be forwarded.
module sb_entry #(
  parameter int STAGES = 3,
  parameter int SW     = 2
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          i_commit,
  input  logic [SW-1:0] i_lat,
  input  logic          i_ex_flush,
  output logic          o_busy,
  output logic [SW-1:0] o_age,
  output logic [SW-1:0] o_ready
);

  localparam logic [SW-1:0] LAST_AGE = SW'(STAGES - 1);

  logic          r_busy;
  logic [SW-1:0] r_age;
  logic [SW-1:0] r_ready;

  // A new writer always reloads the entry, so it wins over retire, flush and advance.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_busy  <= 1'b0;
      r_age   <= '0;
      r_ready <= '0;
    end else if (i_commit) begin
      r_busy  <= 1'b1;
      r_age   <= '0;
      r_ready <= i_lat;
    end else if (r_busy) begin
      if ((i_ex_flush && (r_age == '0)) || (r_age == LAST_AGE)) begin
        r_busy  <= 1'b0;
        r_age   <= '0;
        r_ready <= '0;
      end else begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_age   = r_age;
  assign o_ready = r_ready;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: detects RAW hazards on the read ports, chooses the
// forwarding source per port and records new writers as they leave ID.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int  NUM_REGS = 32,
  parameter int  NUM_RD   = 2,
  parameter int  STAGES   = STAGES_DEF,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int SW       = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [SW-1:0]        issue_lat,
  input  logic                 id_flush,
  input  logic                 ex_flush,
  output logic                 stall,
  output logic [NUM_RD*SW-1:0] fwd_sel,
  output logic [NUM_REGS-1:0]  busy_vec
);

  localparam logic [SW-1:0] LAST_AGE = SW'(STAGES - 1);

  logic [NUM_REGS-1:0] w_busy;
  logic [SW-1:0]       w_age   [NUM_REGS];
  logic [SW-1:0]       w_ready [NUM_REGS];
  logic [SW-1:0]       w_lat;
  logic                w_issue_ok;
  logic [AW-1:0]       w_addr;

  // Register 0 never has a writer in flight.
  assign w_busy[0]  = 1'b0;
  assign w_age[0]   = '0;
  assign w_ready[0] = '0;

  assign w_lat      = (issue_lat > LAST_AGE) ? LAST_AGE : issue_lat;
  assign w_issue_ok = issue_valid && !stall && !id_flush && (issue_rd != '0);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_entry #(
      .STAGES (STAGES),
      .SW     (SW)
    ) u_entry (
      .clk        (clk),
      .reset_b    (reset_b),
      .i_commit   (w_issue_ok && (issue_rd == AW'(i))),
      .i_lat      (w_lat),
      .i_ex_flush (ex_flush),
      .o_busy     (w_busy[i]),
      .o_age      (w_age[i]),
      .o_ready    (w_ready[i])
    );
  end

  // Stall depends only on read ports and entry state, never on issue_*.
  always_comb begin
    stall   = 1'b0;
    fwd_sel = '0;
    w_addr  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_addr = rd_addr[p*AW +: AW];
      if (rd_en[p] && (w_addr != '0) && w_busy[w_addr]) begin
        if (w_age[w_addr] < w_ready[w_addr]) begin
          stall = 1'b1;
        end else begin
          fwd_sel[p*SW +: SW] = w_age[w_addr] + SW'(SEL_EXMEM);
        end
      end
    end
  end

  assign busy_vec = w_busy;

endmodule
